// File: rtl/retospect_fpna_pkg.sv
// Shared types and chain geometry for the neurochip fabric configuration path.
package retospect_fpna_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      SHIFT = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } loader_state_t;

   localparam int CELL_BITS     = 19;
   localparam int CLOCKBOX_BITS = 48;
   localparam int X_MAX         = 5;
   localparam int Y_MAX         = 5;

   // Chain order is clockbox first, then every cell of the X_MAX x Y_MAX grid.
   function automatic int chain_len(input int x, input int y);
      return CLOCKBOX_BITS + x * y * CELL_BITS;
   endfunction

   localparam int FPNA_CHAIN_LEN = chain_len(X_MAX, Y_MAX);

endpackage

// File: rtl/retospect_rb_packer.sv
// Serial-to-byte readback packer: LSB-first accumulation, strobe on every
// 8th bit, and a flush that emits a zero-padded partial byte.
module retospect_rb_packer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sample_en,
   input  logic       bit_in,
   input  logic       flush,
   input  logic       clear,
   output logic [7:0] rb_byte,
   output logic       rb_valid
);

   logic [7:0] acc_q, acc_nxt;
   logic [2:0] idx_q;

   always_comb begin
      acc_nxt        = acc_q;
      acc_nxt[idx_q] = bit_in;
   end

   // acc is zeroed after every emit, so a flushed partial byte is already padded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= 8'h00;
         idx_q    <= 3'd0;
         rb_byte  <= 8'h00;
         rb_valid <= 1'b0;
      end else begin
         rb_valid <= 1'b0;
         if (clear) begin
            acc_q <= 8'h00;
            idx_q <= 3'd0;
         end else if (sample_en) begin
            if (idx_q == 3'd7 || flush) begin
               rb_byte  <= acc_nxt;
               rb_valid <= 1'b1;
               acc_q    <= 8'h00;
               idx_q    <= 3'd0;
            end else begin
               acc_q <= acc_nxt;
               idx_q <= idx_q + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/retospect_bitstream_loader.sv
// Streams configuration bytes LSB-first onto the fabric serial chain with a
// gap-free config_en window, capturing the returning chain bits as readback.
module retospect_bitstream_loader
   import retospect_fpna_pkg::*;
#(
   parameter int CHAIN_LEN = FPNA_CHAIN_LEN,
   parameter int CNT_W     = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       config_en,
   output logic       bs_in,
   input  logic       bs_return,
   output logic [7:0] rb_byte,
   output logic       rb_valid,
   output logic       busy,
   output logic       done,
   output logic       frame_err
);

   localparam int NBYTES = (CHAIN_LEN + 7) / 8;
   localparam int FW     = $clog2(NBYTES + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
   localparam logic [FW-1:0]    NB_F     = FW'(NBYTES);

   loader_state_t    state_q, state_d;
   logic [7:0]       hold_q, hold_d, shreg_q, shreg_d;
   logic             hold_full_q, hold_full_d;
   logic [2:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [FW-1:0]    fetch_q, fetch_d;
   logic             en_q, en_d, done_q, done_d, err_q, err_d, busy_q;
   logic             hs, rb_clear, rb_flush;

   assign byte_ready = (state_q == FILL || state_q == SHIFT) && !hold_full_q && (fetch_q < NB_F);
   assign hs         = byte_ready && byte_valid;

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shreg_d     = shreg_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      fetch_d     = fetch_q;
      en_d        = 1'b0;
      done_d      = 1'b0;
      err_d       = err_q;
      rb_clear    = 1'b0;
      rb_flush    = 1'b0;
      unique case (state_q)
         IDLE: if (start) begin
            state_d     = FILL;
            err_d       = 1'b0;
            cnt_d       = '0;
            idx_d       = 3'd0;
            fetch_d     = '0;
            hold_full_d = 1'b0;
            rb_clear    = 1'b1;
         end
         FILL: if (hs) begin
            shreg_d = byte_in;
            fetch_d = fetch_q + FW'(1);
            state_d = SHIFT;
            en_d    = 1'b1;
         end
         SHIFT: begin
            en_d    = 1'b1;
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            idx_d   = idx_q + 3'd1;
            if (hs) begin
               hold_d      = byte_in;
               hold_full_d = 1'b1;
               fetch_d     = fetch_q + FW'(1);
            end
            if (cnt_q == LAST_BIT) begin
               state_d  = DONE;
               en_d     = 1'b0;
               done_d   = 1'b1;
               shreg_d  = 8'h00;
               rb_flush = 1'b1;
            end else if (idx_q == 3'd7) begin
               // Refill at the boundary with no bubble, or abandon the frame.
               if (hold_full_q) begin
                  shreg_d     = hold_q;
                  hold_full_d = hs;
               end else begin
                  state_d = ERR;
                  en_d    = 1'b0;
                  shreg_d = 8'h00;
               end
            end
         end
         DONE: state_d = IDLE;
         ERR: begin
            err_d       = 1'b1;
            hold_full_d = 1'b0;
            rb_clear    = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         shreg_q     <= 8'h00;
         idx_q       <= 3'd0;
         cnt_q       <= '0;
         fetch_q     <= '0;
         en_q        <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shreg_q     <= shreg_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         fetch_q     <= fetch_d;
         en_q        <= en_d;
         done_q      <= done_d;
         err_q       <= err_d;
         busy_q      <= (state_d != IDLE);
      end
   end

   assign config_en = en_q;
   assign bs_in     = shreg_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign frame_err = err_q;

   retospect_rb_packer u_rb_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (state_q == SHIFT),
      .bit_in    (bs_return),
      .flush     (rb_flush),
      .clear     (rb_clear),
      .rb_byte   (rb_byte),
      .rb_valid  (rb_valid)
   );

endmodule

// File: tb/tb_retospect_bitstream_loader.sv
// Scoreboard bench: a serial-chain model stands in for the fabric; expected
// readback bytes are queued at stimulus time and popped by a monitor.
module tb_retospect_bitstream_loader;

   localparam int N   = 523;
   localparam int NB  = (N + 7) / 8;
   localparam int REM = N - 8 * (NB - 1);

   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, byte_valid = 1'b0;
   logic [7:0] byte_in = 8'h00;
   logic       bs_return;
   logic       byte_ready, config_en, bs_in, rb_valid, busy, done, frame_err;
   logic [7:0] rb_byte;

   int checks = 0, errors = 0;
   logic [7:0] cfg [NB];
   logic [7:0] pre [NB];
   logic [N-1:0] chain, pre_vec, exp_vec;
   logic       pre_load = 1'b0;
   logic [7:0] exp_q [$];
   int  run = 0, last_run = 0, hs_cnt = 0, done_cnt = 0;
   logic prev_en = 1'b0;

   always #5 clk = ~clk;

   retospect_bitstream_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(byte_ready), .config_en(config_en),
      .bs_in(bs_in), .bs_return(bs_return), .rb_byte(rb_byte), .rb_valid(rb_valid),
      .busy(busy), .done(done), .frame_err(frame_err)
   );

   // Fabric chain: shifts in at the near end, bs_out is the far end.
   always @(posedge clk)
      if (pre_load) chain <= pre_vec;
      else if (config_en) chain <= {chain[N-2:0], bs_in};
   assign bs_return = chain[N-1];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: readback scoreboard, config_en run length, handshakes, done.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         run = 0; prev_en = 1'b0;
      end else begin
         if (byte_valid && byte_ready) hs_cnt++;
         if (config_en) run++;
         else begin
            if (prev_en) last_run = run;
            run = 0;
         end
         if (done) begin
            done_cnt++;
            chk("done_after_last_bit", int'(prev_en && !config_en), 1);
         end
         if (rb_valid) begin
            if (exp_q.size() == 0) chk("rb_unexpected", int'(rb_byte), -1);
            else chk("rb_byte", int'(rb_byte), int'(exp_q.pop_front()));
         end
         prev_en = config_en;
      end
   end

   task automatic load_chain();
      for (int i = 0; i < N; i++) pre_vec[N-1-i] = pre[i/8][i%8];
      for (int i = 0; i < N; i++) exp_vec[N-1-i] = cfg[i/8][i%8];
      @(posedge clk); #1 pre_load = 1'b1;
      @(posedge clk); #1 pre_load = 1'b0;
   endtask

   task automatic push_rb(input int n);
      logic [7:0] m;
      m = 8'((1 << REM) - 1);
      for (int k = 0; k < n; k++) exp_q.push_back((k == NB - 1) ? (pre[k] & m) : pre[k]);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic feed(input int n, input bit gaps);
      bit hs;
      for (int k = 0; k < n; k++) begin
         byte_in = cfg[k]; byte_valid = 1'b1; hs = 1'b0;
         for (int w = 0; w < 100 && !hs; w++) begin
            @(negedge clk); hs = byte_ready;
            @(posedge clk); #1;
            if (!rst_n) return;
         end
         if (!hs) begin
            chk("byte_handshake_timeout", k, -1);
            byte_valid = 1'b0;
            return;
         end
         if (gaps) begin
            byte_valid = 1'b0;
            for (int g = $urandom_range(0, 4); g > 0; g--) begin @(posedge clk); #1; end
         end
      end
      if (n < NB) byte_valid = 1'b0;
      else begin byte_valid = 1'b1; byte_in = 8'($urandom); end
   endtask

   task automatic run_frame(input bit gaps, input int restart_at);
      int d0;
      bit got;
      push_rb(NB);
      hs_cnt = 0; d0 = done_cnt;
      pulse_start();
      chk("busy_after_start", int'(busy), 1);
      chk("frame_err_on_start", int'(frame_err), 0);
      fork
         feed(NB, gaps);
         begin
            if (restart_at > 0) begin
               for (int w = 0; w < 2000 && run < restart_at; w++) @(negedge clk);
               #2 start = 1'b1;
               @(posedge clk); #1 start = 1'b0;
            end
         end
      join
      got = 1'b0;
      for (int w = 0; w < 2000 && !got; w++) begin @(negedge clk); got = done; end
      #1;
      chk("done_seen", int'(got), 1);
      chk("frame_len", last_run, N);
      chk("done_count", done_cnt - d0, 1);
      chk("bytes_consumed", hs_cnt, NB);
      chk("chain_contents", int'(chain == exp_vec), 1);
      chk("rb_pending", exp_q.size(), 0);
      chk("frame_err_clean", int'(frame_err), 0);
      byte_valid = 1'b0;
      @(negedge clk); #1;
      chk("busy_after_done", int'(busy), 0);
   endtask

   task automatic randomize_frame();
      for (int k = 0; k < NB; k++) begin cfg[k] = 8'($urandom); pre[k] = 8'($urandom); end
   endtask

   initial begin
      int d0;
      bit got;
      #12;
      chk("rst_config_en", int'(config_en), 0);
      chk("rst_bs_in", int'(bs_in), 0);
      chk("rst_byte_ready", int'(byte_ready), 0);
      chk("rst_rb_byte", int'(rb_byte), 0);
      chk("rst_rb_valid", int'(rb_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_frame_err", int'(frame_err), 0);
      @(negedge clk); rst_n = 1'b1;

      // Readback of a known 0xA5 chain while loading zeros, bytes back-to-back.
      for (int k = 0; k < NB; k++) begin cfg[k] = 8'h00; pre[k] = 8'hA5; end
      load_chain();
      run_frame(1'b0, 0);

      // Random data, random valid gaps, stray start mid-frame.
      randomize_frame();
      load_chain();
      run_frame(1'b1, 100);

      // Underrun: only bytes 0..2 supplied.
      randomize_frame();
      load_chain();
      push_rb(3);
      hs_cnt = 0; d0 = done_cnt;
      pulse_start();
      feed(3, 1'b0);
      got = 1'b0;
      for (int w = 0; w < 200 && !got; w++) begin @(negedge clk); #1; got = !config_en; end
      chk("underrun_fall", int'(got), 1);
      chk("underrun_len", last_run, 24);
      chk("err_busy", int'(busy), 1);
      @(negedge clk); #1;
      chk("err_busy_fall", int'(busy), 0);
      chk("err_frame_err", int'(frame_err), 1);
      chk("err_no_done", done_cnt - d0, 0);
      chk("err_rb_pending", exp_q.size(), 0);
      chk("err_bytes", hs_cnt, 3);

      // Next frame must clear frame_err.
      randomize_frame();
      load_chain();
      run_frame(1'b1, 0);

      // Reset at bit 200.
      randomize_frame();
      load_chain();
      push_rb(25);
      d0 = done_cnt;
      pulse_start();
      fork
         feed(NB, 1'b0);
         begin
            got = 1'b0;
            for (int w = 0; w < 1000 && !got; w++) begin @(negedge clk); #1; got = (run >= 201); end
            chk("reach_bit_200", int'(got), 1);
            #1 rst_n = 1'b0;
            #1;
            chk("mid_rst_config_en", int'(config_en), 0);
            chk("mid_rst_bs_in", int'(bs_in), 0);
            chk("mid_rst_byte_ready", int'(byte_ready), 0);
            chk("mid_rst_rb_byte", int'(rb_byte), 0);
            chk("mid_rst_rb_valid", int'(rb_valid), 0);
            chk("mid_rst_busy", int'(busy), 0);
            chk("mid_rst_done", int'(done), 0);
            chk("mid_rst_rb_pending", exp_q.size(), 0);
         end
      join
      byte_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("mid_rst_no_done", done_cnt - d0, 0);
      chk("mid_rst_idle", int'(busy), 0);

      // Recovery frame after reset.
      randomize_frame();
      load_chain();
      run_frame(1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
